axis_sweep_counter: RTL and testbench



---
 rtl/axis_sweep_counter_if.sv | 27 ++
 rtl/axis_sweep_counter.sv | 122 ++++++++++++
 tb/tb_axis_sweep_counter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_sweep_counter_if.sv
// axis_sweep_counter_if: sweep request, limit inputs and step/completion
// outputs of one servo-axis sweep generator, bundled for port connection.
// The slave modport is the generator side; the master modport is the
// calibration FSM / position counter side.
interface axis_sweep_counter_if #(
  parameter int CNT_W = 13
);
  logic             SWEEP_EN;
  logic             DIR;
  logic             PWM_LIMIT_HI;
  logic             PWM_LIMIT_LO;
  logic             CNT_U;
  logic             CNT_D;
  logic             SWEEP_DONE;
  logic             SWEEP_TO;
  logic [CNT_W-1:0] SWEEP_CNT;

  modport master (
    output SWEEP_EN, DIR, PWM_LIMIT_HI, PWM_LIMIT_LO,
    input  CNT_U, CNT_D, SWEEP_DONE, SWEEP_TO, SWEEP_CNT
  );

  modport slave (
    input  SWEEP_EN, DIR, PWM_LIMIT_HI, PWM_LIMIT_LO,
    output CNT_U, CNT_D, SWEEP_DONE, SWEEP_TO, SWEEP_CNT
  );
endinterface

// File: rtl/axis_sweep_counter.sv
// axis_sweep_counter: rate-divided sweep-step generator for one servo axis.
// On a sweep request it emits single-cycle CNT_U or CNT_D pulses every
// STEP_DIV cycles until the end-stop for the latched direction is reached
// or the request is withdrawn. Completion is flagged by a one-cycle
// SWEEP_DONE pulse and the number of steps issued is kept in SWEEP_CNT.
//
// Optional feature macro: SWEEP_TIMEOUT_EN
//   defined   -> a sweep also ends after MAX_STEPS steps, flagged on SWEEP_TO
//   undefined -> no step budget; SWEEP_TO stays 0
module axis_sweep_counter #(
  parameter int CNT_W     = 13,
  parameter int STEP_DIV  = 4,
  parameter int MAX_STEPS = 4095
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  axis_sweep_counter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Divider is 16 bits wide so that STEP_DIV may go up to 2^16-1.
  localparam logic [15:0]      DIV_LAST = 16'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MAX_Q    = CNT_W'(MAX_STEPS);

`ifdef SWEEP_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t           state_q;
  logic             dir_q;
  logic [15:0]      div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_u_q;
  logic             cnt_d_q;
  logic             done_q;
  logic             to_q;

  logic limit_hit;
  logic step_point;
  logic budget_hit;

  // Only the end-stop in the latched sweep direction can stop the sweep;
  // with the timeout feature compiled out the budget term is constant 0.
  always_comb begin
    limit_hit  = dir_q ? bus.PWM_LIMIT_HI : bus.PWM_LIMIT_LO;
    step_point = (div_q == DIV_LAST);
    budget_hit = TIMEOUT_EN && (cnt_q == MAX_Q);
  end

  // Sweep state machine with registered pulse, completion and count outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      dir_q   <= 1'b0;
      div_q   <= '0;
      cnt_q   <= '0;
      cnt_u_q <= 1'b0;
      cnt_d_q <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      cnt_u_q <= 1'b0;
      cnt_d_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.SWEEP_EN) begin
            state_q <= SWEEP;
            dir_q   <= bus.DIR;
            div_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
          end
        end
        SWEEP: begin
          if (!bus.SWEEP_EN) begin
            state_q <= IDLE;
          end else if (limit_hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else if (step_point && budget_hit) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            to_q    <= 1'b1;
          end else if (step_point) begin
            cnt_u_q <= dir_q;
            cnt_d_q <= ~dir_q;
            div_q   <= '0;
            if (cnt_q != CNT_MAX) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            div_q <= div_q + 16'd1;
          end
        end
        DONE: begin
          if (!bus.SWEEP_EN) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.CNT_U      = cnt_u_q;
  assign bus.CNT_D      = cnt_d_q;
  assign bus.SWEEP_DONE = done_q;
  assign bus.SWEEP_TO   = to_q;
  assign bus.SWEEP_CNT  = cnt_q;

endmodule

// File: tb/tb_axis_sweep_counter.sv
// tb_axis_sweep_counter: scoreboard bench for axis_sweep_counter.
// dut0 runs with STEP_DIV=4, MAX_STEPS=5; dut1 runs with STEP_DIV=1.
// Expected pulse/done events (cycle, kind, count, timeout flag) are queued
// when each sweep is started; per-DUT monitors pop and compare them on the
// falling edge whenever a DUT shows CNT_U, CNT_D or SWEEP_DONE.
// Honours SWEEP_TIMEOUT_EN the same way the design does.
module tb_axis_sweep_counter;

  typedef struct {
    int   cyc;
    logic u;
    logic d;
    logic done;
    logic to;
    int   cnt;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q0[$];
  exp_t q1[$];

  axis_sweep_counter_if #(.CNT_W(13)) bus0 ();
  axis_sweep_counter_if #(.CNT_W(13)) bus1 ();

  axis_sweep_counter #(.CNT_W(13), .STEP_DIV(4), .MAX_STEPS(5)) dut0 (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus0)
  );

  axis_sweep_counter #(.CNT_W(13), .STEP_DIV(1), .MAX_STEPS(4095)) dut1 (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus1)
  );

  // 10-time-unit clock.
  always #5 CLK = ~CLK;

  // Edge counter: at a falling edge, cyc is the number of rising edges seen.
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expectEvent(input int idx, input int c, input logic u, input logic d,
                             input logic done, input logic to, input int cnt);
    exp_t e;
    e.cyc = c; e.u = u; e.d = d; e.done = done; e.to = to; e.cnt = cnt;
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic checkEvent(input int idx, input logic u, input logic d, input logic done,
                            input logic to, input int cnt);
    exp_t e;
    logic found;
    found = 1'b0;
    if (idx == 0 && q0.size() > 0) begin
      e = q0.pop_front(); found = 1'b1;
    end else if (idx == 1 && q1.size() > 0) begin
      e = q1.pop_front(); found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL dut%0d_unexpected_event: got u=%0b d=%0b done=%0b cnt=%0d at cycle %0d, expected no event",
               idx, u, d, done, cnt, cyc);
    end else begin
      checkOutput($sformatf("dut%0d_event_cycle", idx), cyc, e.cyc);
      checkOutput($sformatf("dut%0d_event_kind_udd", idx), int'({u, d, done}), int'({e.u, e.d, e.done}));
      checkOutput($sformatf("dut%0d_event_sweep_to", idx), int'(to), int'(e.to));
      checkOutput($sformatf("dut%0d_event_sweep_cnt", idx), cnt, e.cnt);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic en, input logic dir,
                               input logic hi, input logic lo);
    if (idx == 0) begin
      bus0.SWEEP_EN = en; bus0.DIR = dir; bus0.PWM_LIMIT_HI = hi; bus0.PWM_LIMIT_LO = lo;
    end else begin
      bus1.SWEEP_EN = en; bus1.DIR = dir; bus1.PWM_LIMIT_HI = hi; bus1.PWM_LIMIT_LO = lo;
    end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  task automatic checkQuiet0(input string tag, input int cnt, input logic to);
    checkOutput({tag, "_cnt_u"}, int'(bus0.CNT_U), 0);
    checkOutput({tag, "_cnt_d"}, int'(bus0.CNT_D), 0);
    checkOutput({tag, "_done"}, int'(bus0.SWEEP_DONE), 0);
    checkOutput({tag, "_to"}, int'(bus0.SWEEP_TO), int'(to));
    checkOutput({tag, "_sweep_cnt"}, int'(bus0.SWEEP_CNT), cnt);
  endtask

  // Monitor for dut0: every visible pulse or completion must match the queue head.
  always @(negedge CLK) begin
    if (bus0.CNT_U || bus0.CNT_D || bus0.SWEEP_DONE)
      checkEvent(0, bus0.CNT_U, bus0.CNT_D, bus0.SWEEP_DONE, bus0.SWEEP_TO, int'(bus0.SWEEP_CNT));
  end

  // Monitor for dut1.
  always @(negedge CLK) begin
    if (bus1.CNT_U || bus1.CNT_D || bus1.SWEEP_DONE)
      checkEvent(1, bus1.CNT_U, bus1.CNT_D, bus1.SWEEP_DONE, bus1.SWEEP_TO, int'(bus1.SWEEP_CNT));
  end

  // Directed stimulus sequence.
  initial begin
    int t;
    int t2;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset values while reset is held.
    repeat (2) @(negedge CLK);
    checkQuiet0("reset0", 0, 1'b0);
    checkOutput("reset1_sweep_cnt", int'(bus1.SWEEP_CNT), 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Up sweep, end-stop raised between the 3rd and 4th pulse.
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
    t = cyc + 1;
    for (int k = 1; k <= 3; k++) expectEvent(0, t + 4 * k, 1'b1, 1'b0, 1'b0, 1'b0, k);
    expectEvent(0, t + 14, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    waitUntil(t + 13);
    applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0);
    waitUntil(t + 17);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0);
    waitUntil(t + 20);
    checkQuiet0("up_hold", 3, 1'b0);

    // Wrong-side limit held throughout, then abort after two pulses.
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b1);
    t = cyc + 1;
    expectEvent(0, t + 4, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    expectEvent(0, t + 8, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    waitUntil(t + 9);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1);
    waitUntil(t + 14);
    checkQuiet0("abort_hold", 2, 1'b0);

    // Re-raise clears the count; down-limit lands exactly on the 2nd step point.
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    t2 = cyc + 1;
    waitUntil(t2);
    checkOutput("restart_cnt_cleared", int'(bus0.SWEEP_CNT), 0);
    expectEvent(0, t2 + 4, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    expectEvent(0, t2 + 8, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    waitUntil(t2 + 7);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b1);
    waitUntil(t2 + 11);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitUntil(t2 + 13);

    // Down sweep with no limits: budget of 5 steps, or free-running without it.
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0);
    t = cyc + 1;
    for (int k = 1; k <= 5; k++) expectEvent(0, t + 4 * k, 1'b0, 1'b1, 1'b0, 1'b0, k);
`ifdef SWEEP_TIMEOUT_EN
    expectEvent(0, t + 24, 1'b0, 1'b0, 1'b1, 1'b1, 5);
`else
    expectEvent(0, t + 24, 1'b0, 1'b1, 1'b0, 1'b0, 6);
    expectEvent(0, t + 28, 1'b0, 1'b1, 1'b0, 1'b0, 7);
`endif
    waitUntil(t + 29);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitUntil(t + 31);
`ifdef SWEEP_TIMEOUT_EN
    checkQuiet0("budget_hold", 5, 1'b1);
`else
    checkQuiet0("budget_hold", 7, 1'b0);
`endif

    // STEP_DIV=1: pulse every cycle, DIR flip ignored, limit on a step point wins.
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0);
    t = cyc + 1;
    for (int k = 1; k <= 5; k++) expectEvent(1, t + k, 1'b1, 1'b0, 1'b0, 1'b0, k);
    expectEvent(1, t + 6, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    waitUntil(t + 2);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0);
    waitUntil(t + 5);
    applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0);
    waitUntil(t + 8);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0);
    // SWEEP_EN stays high after completion: no restart may occur.
    waitUntil(t + 20);
    checkOutput("done_hold_cnt", int'(bus1.SWEEP_CNT), 5);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitUntil(t + 22);

    // Limit already active at sweep entry: done after one sweep cycle, count 0.
    applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b0);
    t2 = cyc + 1;
    expectEvent(1, t2 + 1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    waitUntil(t2 + 3);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0);
    waitUntil(t2 + 5);

    // Asynchronous reset in the middle of a step pulse.
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
    t = cyc + 1;
    expectEvent(0, t + 4, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    waitUntil(t + 4);
    #2;
    RST_N = 1'b0;
    #1;
    checkQuiet0("midpulse_reset", 0, 1'b0);
    @(negedge CLK);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    RST_N = 1'b1;
    waitUntil(cyc + 3);
    checkQuiet0("post_reset_idle", 0, 1'b0);

    // A fresh sweep works normally after reset release.
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0);
    t = cyc + 1;
    expectEvent(0, t + 4, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    waitUntil(t + 5);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitUntil(t + 8);

    // Every queued event must have been observed.
    checkOutput("dut0_events_left", q0.size(), 0);
    checkOutput("dut1_events_left", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
